cla_seq_adder: RTL and testbench
================================

Name: cla_seq_adder

Overview:
Multi-cycle wide adder controller that sequences one 4-bit carry-lookahead slice over WIDTH-bit operands, one nibble per cycle, least significant nibble first.
- The slice carry-out is registered and fed back as the carry-in of the next nibble.
- Valid/ready on both input and output.
- Serves as the low-area alternative to a full-width lookahead adder where throughput is not critical.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4 (otherwise elaboration error)
NSLICE, WIDTH/4, derived local constant: number of slice passes per operation

Ports:
clk  input  1  single clock, rising-edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  operand request valid
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  initial carry-in
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result
cout  output  1  final carry-out
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; in_ready=1, out_valid=0, busy=0, sum=0, cout=0.
  - Nibble index, carry register and operand registers cleared.
  - Reset wins over every other event, including mid-RUN and DONE. An in-flight operation is dropped with no output.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture a, b into operand registers; carry register <= cin; idx <= 0; go to RUN.
- RUN:
  - in_ready=0, busy=1.
  - Each edge feeds the slice with a[idx*4+:4], b[idx*4+:4] and the carry register.
  - sum[idx*4+:4] <= slice sum; carry register <= slice cout; idx <= idx+1.
  - On the edge where idx==NSLICE-1: cout <= slice cout; go to DONE.
- DONE:
  - out_valid=1; sum and cout held stable.
  - On out_valid&&out_ready: go to IDLE, out_valid drops on that edge.
- Latency: if operands are accepted at edge T, out_valid is high after edge T+NSLICE (4 cycles for WIDTH=16).
- Throughput: at most one operation per NSLICE+2 cycles. No back-to-back accept, because in_ready is 0 during DONE, including the cycle in which the result handshake occurs. The earliest next accept is the cycle after the result handshake.
- Input side: a, b and cin are ignored outside the accept cycle. in_valid held high while busy causes no effect.
- Arithmetic: {cout,sum} == a + b + cin, modulo 2^(WIDTH+1), unsigned.
- sum keeps its last value in IDLE until it is overwritten nibble-by-nibble in the next RUN. Only sampling in DONE is defined.
- Slice carry equations are full lookahead within the nibble (generate = a&b, propagate = a^b), and carries ripple between nibbles via the register only.

Optional Feature:
Macro CLA_SEQ_OVF_EN.
- Defined:
  - Extra output port ovf (1 bit), reset 0.
  - In the final RUN edge, ovf <= carry into bit WIDTH-1 XOR carry out of bit WIDTH-1 (two's-complement signed overflow).
  - The slice exposes its internal bit-3 carry-in for this purpose.
  - ovf is valid and held with out_valid.
- Undefined: no ovf port, no extra logic; behaviour otherwise identical.

Decomposition:
- Shared package cla_pkg:
  - SLICE_W = 4.
  - State enum typedef cla_seq_state_t {IDLE, RUN, DONE}.
  - Function to compute NSLICE from WIDTH.
- One sub-module: cla4_slice.
  - Purely combinational 4-bit lookahead.
  - Inputs: a[3:0], b[3:0], ci.
  - Outputs: s[3:0], co, c3 (carry into bit 3, used only when CLA_SEQ_OVF_EN).
- The controller owns all registers and the FSM.

Test Plan:
- WIDTH=16, a=0x1234, b=0x4321, cin=0, out_ready=1 -> out_valid after exactly 4 cycles; sum=0x5555, cout=0; in_ready returns 1 the cycle after the handshake.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1 (carry crosses every nibble register). Repeat with a=0xFFFF, b=0x0000, cin=1 -> same result.
- Backpressure: a=0x00F0, b=0x0F10, out_ready=0 for 6 cycles after out_valid -> sum=0x1000, cout=0 held stable; in_ready=0 and busy=1 throughout; new in_valid with different operands ignored.
- Reset mid-RUN: accept a=0xAAAA, b=0x5555, deassert rst_n at the 2nd RUN edge -> next cycle state IDLE, in_ready=1, out_valid=0, sum=0, cout=0; a following add of 0x0001+0x0001 gives 0x0002.
- Random regression: 1000 random a, b, cin with random out_ready gaps -> {cout,sum} equals the a+b+cin reference, one result per accepted request, in order.
- With CLA_SEQ_OVF_EN:
  - 0x7FFF+0x0001 -> sum=0x8000, cout=0, ovf=1.
  - 0x8000+0x8000 -> sum=0x0000, cout=1, ovf=1.
  - 0xFFFF+0x0001 -> ovf=0.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared types and constants for the nibble-serial lookahead adder.
package cla_pkg;

    localparam int unsigned SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cla_seq_state_t;

    // Number of slice passes needed to cover a width-bit operand.
    function automatic int unsigned num_slices(input int unsigned width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry-lookahead slice.
// With CLA_SEQ_OVF_EN defined the carry into bit 3 is also exported.
module cla4_slice
    import cla_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               ci,
    output logic [SLICE_W-1:0] s,
    output logic               co
`ifdef CLA_SEQ_OVF_EN
    ,
    output logic               c3
`endif
);

    logic [SLICE_W-1:0] g;
    logic [SLICE_W-1:0] p;
    logic [SLICE_W:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is a flat sum of products of generate/propagate terms.
    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & ci);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);

    assign s  = p ^ c[SLICE_W-1:0];
    assign co = c[4];

`ifdef CLA_SEQ_OVF_EN
    assign c3 = c[3];
`endif

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit lookahead slice reused per nibble, LSB first.
// Optional signed-overflow output ovf when CLA_SEQ_OVF_EN is defined.
module cla_seq_adder
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef CLA_SEQ_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned NSLICE = num_slices(WIDTH);
    localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    if ((WIDTH < SLICE_W) || ((WIDTH % SLICE_W) != 0)) begin : g_width_check
        $error("cla_seq_adder: WIDTH must be a multiple of 4 and at least 4");
    end

    cla_seq_state_t                       state;
    logic [IDX_W-1:0]                     idx;
    logic                                 carry;
    logic [NSLICE-1:0][SLICE_W-1:0]       a_q;
    logic [NSLICE-1:0][SLICE_W-1:0]       b_q;
    logic [NSLICE-1:0][SLICE_W-1:0]       sum_q;

    logic [SLICE_W-1:0] slice_s;
    logic               slice_co;
`ifdef CLA_SEQ_OVF_EN
    logic               slice_c3;
`endif

    cla4_slice u_slice (
        .a  (a_q[idx]),
        .b  (b_q[idx]),
        .ci (carry),
        .s  (slice_s),
        .co (slice_co)
`ifdef CLA_SEQ_OVF_EN
        ,
        .c3 (slice_c3)
`endif
    );

    assign sum = sum_q;

    // Controller: handshakes, nibble sequencing and carry feedback.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            cout      <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q      <= a;
                        b_q      <= b;
                        carry    <= cin;
                        idx      <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    sum_q[idx] <= slice_s;
                    carry      <= slice_co;
                    idx        <= idx + IDX_W'(1);
                    if (idx == LAST_IDX) begin
                        cout      <= slice_co;
                        out_valid <= 1'b1;
                        state     <= DONE;
`ifdef CLA_SEQ_OVF_EN
                        ovf       <= slice_c3 ^ slice_co;
`endif
                    end
                end
                DONE: begin
                    // in_ready stays low through the handshake cycle itself.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_seq_adder.sv
// Self-checking bench for cla_seq_adder (WIDTH=16); covers ovf when CLA_SEQ_OVF_EN is defined.
module tb_cla_seq_adder;

    localparam int unsigned W = 16;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
`ifdef CLA_SEQ_OVF_EN
    logic         ovf;
`endif

    int checks;
    int failures;

    cla_seq_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
`ifdef CLA_SEQ_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: unsigned sum of the operands plus carry-in, one bit wider.
    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    // Reference: two's-complement overflow from operand and result signs.
    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                     input logic c);
        logic [W:0] r;
        r = ref_add(x, y, c);
        return (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    endfunction

    // Present operands until accepted, then scramble the inputs.
    task automatic start_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                            input logic xc, output bit ok);
        int n;
        n = 0;
        a = xa; b = xb; cin = xc; in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        ok = in_ready;
        step();
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    endtask

    task automatic wait_valid(input int max_cycles, output int n);
        n = 0;
        while (!out_valid && n < max_cycles) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        a = 16'hDEAD; b = 16'hBEEF; cin = 1'b1;
        step(); step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags got in_ready=%b out_valid=%b busy=%b exp 1 0 0",
                     in_ready, out_valid, busy);
        end
        checks++;
        if (sum !== 16'h0000 || cout !== 1'b0) begin
            failures++;
            $display("FAIL reset_data got sum=%h cout=%b exp 0000 0", sum, cout);
        end
`ifdef CLA_SEQ_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_ovf got %b exp 0", ovf);
        end
`endif
        in_valid = 1'b0;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        bit ok;
        int n;
        out_ready = 1'b1;
        start_op(16'h1234, 16'h4321, 1'b0, ok);
        checks++;
        if (!ok || busy !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL basic_accept got ok=%b busy=%b in_ready=%b exp 1 1 0", ok, busy, in_ready);
        end
        wait_valid(10, n);
        checks++;
        if (n != 4) begin
            failures++;
            $display("FAIL basic_latency got %0d cycles exp 4", n);
        end
        checks++;
        if (sum !== 16'h5555 || cout !== 1'b0) begin
            failures++;
            $display("FAIL basic_sum got %h/%b exp 5555/0", sum, cout);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_release got out_valid=%b in_ready=%b busy=%b exp 0 1 0",
                     out_valid, in_ready, busy);
        end
    endtask

    task automatic test_carry_chain();
        logic [W-1:0] ta [2] = '{16'hFFFF, 16'hFFFF};
        logic [W-1:0] tb [2] = '{16'h0001, 16'h0000};
        logic         tc [2] = '{1'b0, 1'b1};
        bit ok;
        int n;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start_op(ta[i], tb[i], tc[i], ok);
            wait_valid(10, n);
            checks++;
            if (!ok || n != 4 || sum !== 16'h0000 || cout !== 1'b1) begin
                failures++;
                $display("FAIL carry_chain_%0d got ok=%b lat=%0d sum=%h cout=%b exp 1 4 0000 1",
                         i, ok, n, sum, cout);
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int n;
        out_ready = 1'b0;
        start_op(16'h00F0, 16'h0F10, 1'b0, ok);
        wait_valid(10, n);
        checks++;
        if (!ok || n != 4) begin
            failures++;
            $display("FAIL bp_latency got ok=%b lat=%0d exp 1 4", ok, n);
        end
        in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1
                || sum !== 16'h1000 || cout !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold_%0d got ov=%b ir=%b busy=%b sum=%h cout=%b exp 1 0 1 1000 0",
                         i, out_valid, in_ready, busy, sum, cout);
            end
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL bp_release got ov=%b ir=%b busy=%b exp 0 1 0", out_valid, in_ready, busy);
        end
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        int n;
        bit seen;
        out_ready = 1'b1;
        start_op(16'hAAAA, 16'h5555, 1'b0, ok);
        step();
        rst_n = 1'b0;
        step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0
            || sum !== 16'h0000 || cout !== 1'b0) begin
            failures++;
            $display("FAIL midrun_reset got ir=%b ov=%b busy=%b sum=%h cout=%b exp 1 0 0 0000 0",
                     in_ready, out_valid, busy, sum, cout);
        end
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) seen = 1'b1;
            step();
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL midrun_dropped got out_valid=1 after reset exp 0");
        end
        start_op(16'h0001, 16'h0001, 1'b0, ok);
        wait_valid(10, n);
        checks++;
        if (!ok || n != 4 || sum !== 16'h0002 || cout !== 1'b0) begin
            failures++;
            $display("FAIL midrun_next got ok=%b lat=%0d sum=%h cout=%b exp 1 4 0002 0",
                     ok, n, sum, cout);
        end
        step();
    endtask

    task automatic test_random();
        logic [W-1:0] xa;
        logic [W-1:0] xb;
        logic         xc;
        logic [W:0]   expv;
        bit ok;
        int n;
        int gap;
        for (int i = 0; i < 1000; i++) begin
            xa = W'($urandom); xb = W'($urandom); xc = 1'($urandom);
            if (i == 0) begin xa = 16'hFFFF; xb = 16'hFFFF; xc = 1'b1; end
            expv = ref_add(xa, xb, xc);
            gap = $urandom_range(0, 3);
            out_ready = 1'b0;
            start_op(xa, xb, xc, ok);
            in_valid = 1'($urandom);
            wait_valid(20, n);
            in_valid = 1'b0;
            checks++;
            if (!ok || n != 4) begin
                failures++;
                $display("FAIL rand_latency_%0d got ok=%b lat=%0d exp 1 4", i, ok, n);
            end
            for (int g = 0; g < gap; g++) step();
            out_ready = 1'b1;
            checks++;
            if ({cout, sum} !== expv) begin
                failures++;
                $display("FAIL rand_sum_%0d a=%h b=%h cin=%b got %h exp %h", i, xa, xb, xc,
                         {cout, sum}, expv);
            end
`ifdef CLA_SEQ_OVF_EN
            checks++;
            if (ovf !== ref_ovf(xa, xb, xc)) begin
                failures++;
                $display("FAIL rand_ovf_%0d a=%h b=%h cin=%b got %b exp %b", i, xa, xb, xc,
                         ovf, ref_ovf(xa, xb, xc));
            end
`endif
            step();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL rand_single_%0d got ov=%b ir=%b exp 0 1", i, out_valid, in_ready);
            end
        end
    endtask

`ifdef CLA_SEQ_OVF_EN
    task automatic test_ovf();
        logic [W-1:0] ta [3] = '{16'h7FFF, 16'h8000, 16'hFFFF};
        logic [W-1:0] tb [3] = '{16'h0001, 16'h8000, 16'h0001};
        logic [W-1:0] es [3] = '{16'h8000, 16'h0000, 16'h0000};
        logic         ec [3] = '{1'b0, 1'b1, 1'b1};
        logic         eo [3] = '{1'b1, 1'b1, 1'b0};
        bit ok;
        int n;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start_op(ta[i], tb[i], 1'b0, ok);
            wait_valid(10, n);
            checks++;
            if (!ok || sum !== es[i] || cout !== ec[i] || ovf !== eo[i]) begin
                failures++;
                $display("FAIL ovf_case_%0d got sum=%h cout=%b ovf=%b exp %h %b %b",
                         i, sum, cout, ovf, es[i], ec[i], eo[i]);
            end
            step();
        end
    endtask
`endif

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        test_reset();
        test_basic();
        test_carry_chain();
        test_backpressure();
        test_reset_mid_run();
`ifdef CLA_SEQ_OVF_EN
        test_ovf();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
